keypad_matrix_loader: RTL and testbench

Parametrised keypad-entry front end that turns the 4-bit keypad decoder code stream into a packed signed matrix for the regression datapath.
- Replaces the single free-running data_in latch with per-keypress edge detection, multi-digit decimal accumulation, sign entry, clear, and saturation.
- Adds row/column element indexing, generic R x C packing and a valid/ack handshake toward the consumer.
- Sits between Decoder and the matrix compute block; entry_value, row_idx and col_idx also feed color_gen for on-screen echo.

---
 rtl/keypad_matrix_loader_if.sv | 41 ++++
 rtl/keypad_matrix_loader.sv | 179 +++++++++++++++++
 tb/tb_keypad_matrix_loader.sv | 217 +++++++++++++++++++++
 3 files changed

// File: rtl/keypad_matrix_loader_if.sv
// Keypad loader bus: decoder key stream and consumer hand-off toward the loader.
// Signals:
//   key_code/key_valid      : decoder key stream (master -> slave)
//   matrix_ack              : consumer pulse, matrix taken (master -> slave)
//   matrix_out              : packed R x C signed matrix (slave -> master)
//   entry_value/row_idx/col_idx : entry echo for display (slave -> master)
//   ready/matrix_valid      : LOAD / DONE state indications (slave -> master)
//   error_overflow/error_incomplete : sticky entry errors (slave -> master)
interface keypad_matrix_loader_if #(
    parameter int unsigned ELEM_WIDTH = 12,
    parameter int unsigned NUM_ROWS   = 3,
    parameter int unsigned NUM_COLS   = 2
);
    localparam int unsigned RW    = (NUM_ROWS > 1) ? $clog2(NUM_ROWS) : 1;
    localparam int unsigned CW    = (NUM_COLS > 1) ? $clog2(NUM_COLS) : 1;
    localparam int unsigned MAT_W = NUM_ROWS * NUM_COLS * ELEM_WIDTH;

    logic [3:0]            key_code;
    logic                  key_valid;
    logic                  matrix_ack;
    logic [MAT_W-1:0]      matrix_out;
    logic [ELEM_WIDTH-1:0] entry_value;
    logic [RW-1:0]         row_idx;
    logic [CW-1:0]         col_idx;
    logic                  ready;
    logic                  matrix_valid;
    logic                  error_overflow;
    logic                  error_incomplete;

    modport master (
        output key_code, key_valid, matrix_ack,
        input  matrix_out, entry_value, row_idx, col_idx, ready, matrix_valid,
               error_overflow, error_incomplete
    );

    modport slave (
        input  key_code, key_valid, matrix_ack,
        output matrix_out, entry_value, row_idx, col_idx, ready, matrix_valid,
               error_overflow, error_incomplete
    );
endinterface

// File: rtl/keypad_matrix_loader.sv
// Keypad entry front end: turns keypress events into signed decimal entries,
// packs them into an R x C matrix and hands the matrix off with valid/ack.
// Ports:
//   clock : system clock
//   reset : asynchronous active-low reset
//   bus   : keypad_matrix_loader_if slave (key stream in, matrix/status out)
module keypad_matrix_loader #(
    parameter int unsigned ELEM_WIDTH = 12,
    parameter int unsigned NUM_ROWS   = 3,
    parameter int unsigned NUM_COLS   = 2,
    parameter logic [3:0]  KEY_NEG    = 4'hA,
    parameter logic [3:0]  KEY_CLR    = 4'hC,
    parameter logic [3:0]  KEY_DONE   = 4'hD,
    parameter logic [3:0]  KEY_ENTER  = 4'hE
) (
    input  logic                   clock,
    input  logic                   reset,
    keypad_matrix_loader_if.slave  bus
);
    localparam int unsigned EW    = ELEM_WIDTH;
    localparam int unsigned MW    = ELEM_WIDTH - 1;
    localparam int unsigned PW    = MW + 5;
    localparam int unsigned RW    = (NUM_ROWS > 1) ? $clog2(NUM_ROWS) : 1;
    localparam int unsigned CW    = (NUM_COLS > 1) ? $clog2(NUM_COLS) : 1;
    localparam int unsigned MAT_W = NUM_ROWS * NUM_COLS * ELEM_WIDTH;

    localparam logic [PW-1:0] MAG_MAX  = PW'((2 ** MW) - 1);
    localparam logic [RW-1:0] ROW_LAST = RW'(NUM_ROWS - 1);
    localparam logic [CW-1:0] COL_LAST = CW'(NUM_COLS - 1);

    typedef enum logic [1:0] {
        ST_LOAD = 2'd0,
        ST_FULL = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic             key_valid_q;
    logic [MW-1:0]    mag_q, mag_d;
    logic             sign_q, sign_d;
    logic [RW-1:0]    row_q, row_d;
    logic [CW-1:0]    col_q, col_d;
    logic [MAT_W-1:0] mat_q, mat_d;
    logic             ovf_q, ovf_d;
    logic             inc_q, inc_d;
    logic [EW-1:0]    entry_q, entry_d;
    logic             ready_q, ready_d;
    logic             valid_q, valid_d;

    logic             key_evt;
    logic [PW-1:0]    prod;
    logic [EW-1:0]    mag_ext;

    // A held key produces one event: rising edge of key_valid.
    assign key_evt = bus.key_valid && !key_valid_q;

    // State register and all registered outputs.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q     <= ST_LOAD;
            key_valid_q <= 1'b0;
            mag_q       <= '0;
            sign_q      <= 1'b0;
            row_q       <= '0;
            col_q       <= '0;
            mat_q       <= '0;
            ovf_q       <= 1'b0;
            inc_q       <= 1'b0;
            entry_q     <= '0;
            ready_q     <= 1'b1;
            valid_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            key_valid_q <= bus.key_valid;
            mag_q       <= mag_d;
            sign_q      <= sign_d;
            row_q       <= row_d;
            col_q       <= col_d;
            mat_q       <= mat_d;
            ovf_q       <= ovf_d;
            inc_q       <= inc_d;
            entry_q     <= entry_d;
            ready_q     <= ready_d;
            valid_q     <= valid_d;
        end
    end

    // Next-state and output logic.
    always_comb begin
        state_d = state_q;
        mag_d   = mag_q;
        sign_d  = sign_q;
        row_d   = row_q;
        col_d   = col_q;
        mat_d   = mat_q;
        ovf_d   = ovf_q;
        inc_d   = inc_q;
        prod    = PW'(mag_q) * PW'(10) + PW'(bus.key_code);

        unique case (state_q)
            ST_LOAD: begin
                if (key_evt) begin
                    if (bus.key_code <= 4'd9) begin
                        if (prod > MAG_MAX) begin
                            mag_d = MW'(MAG_MAX);
                            ovf_d = 1'b1;
                        end else begin
                            mag_d = MW'(prod);
                        end
                    end else if (bus.key_code == KEY_NEG) begin
                        sign_d = ~sign_q;
                    end else if (bus.key_code == KEY_CLR) begin
                        mag_d  = '0;
                        sign_d = 1'b0;
                    end else if (bus.key_code == KEY_ENTER) begin
                        // Commit the displayed entry to the current element.
                        for (int r = 0; r < int'(NUM_ROWS); r++) begin
                            for (int c = 0; c < int'(NUM_COLS); c++) begin
                                if (row_q == RW'(r) && col_q == CW'(c)) begin
                                    mat_d[(r * int'(NUM_COLS) + c) * int'(EW) +: EW] = entry_q;
                                end
                            end
                        end
                        mag_d  = '0;
                        sign_d = 1'b0;
                        if (col_q == COL_LAST) begin
                            col_d = '0;
                            if (row_q == ROW_LAST) begin
                                row_d   = '0;
                                state_d = ST_FULL;
                            end else begin
                                row_d = row_q + RW'(1);
                            end
                        end else begin
                            col_d = col_q + CW'(1);
                        end
                    end else if (bus.key_code == KEY_DONE) begin
                        inc_d = 1'b1;
                    end
                end
            end
            ST_FULL: begin
                if (key_evt && bus.key_code == KEY_DONE) begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                // Ack wins over any simultaneous key; keys are ignored here anyway.
                if (bus.matrix_ack) begin
                    state_d = ST_LOAD;
                    mat_d   = '0;
                    row_d   = '0;
                    col_d   = '0;
                    mag_d   = '0;
                    sign_d  = 1'b0;
                    ovf_d   = 1'b0;
                    inc_d   = 1'b0;
                end
            end
            default: begin
                state_d = ST_LOAD;
            end
        endcase

        mag_ext = {1'b0, mag_d};
        entry_d = sign_d ? (~mag_ext + EW'(1)) : mag_ext;
        ready_d = (state_d == ST_LOAD);
        valid_d = (state_d == ST_DONE);
    end

    assign bus.matrix_out       = mat_q;
    assign bus.entry_value      = entry_q;
    assign bus.row_idx          = row_q;
    assign bus.col_idx          = col_q;
    assign bus.ready            = ready_q;
    assign bus.matrix_valid     = valid_q;
    assign bus.error_overflow   = ovf_q;
    assign bus.error_incomplete = inc_q;
endmodule

// File: tb/tb_keypad_matrix_loader.sv
// Scoreboard bench for keypad_matrix_loader with directed keypress vectors.
module tb_keypad_matrix_loader;
    localparam int unsigned EW    = 12;
    localparam int unsigned MAT_W = 72;

    typedef struct packed {
        logic [EW-1:0]    entry;
        logic             row;
        logic [1:0]       rowv;
        logic             col;
        logic             ready;
        logic             mvalid;
        logic             ovf;
        logic             inc;
        logic [MAT_W-1:0] mat;
    } snap_t;

    logic clock;
    logic reset;

    keypad_matrix_loader_if #(.ELEM_WIDTH(12), .NUM_ROWS(3), .NUM_COLS(2)) bus ();

    keypad_matrix_loader #(
        .ELEM_WIDTH(12), .NUM_ROWS(3), .NUM_COLS(2),
        .KEY_NEG(4'hA), .KEY_CLR(4'hC), .KEY_DONE(4'hD), .KEY_ENTER(4'hE)
    ) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus.slave)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    snap_t            snap_q[$];
    logic [MAT_W-1:0] hand_q[$];
    int               n_cmp = 0;
    int               n_bad = 0;
    logic             mv_prev = 1'b0;
    logic [MAT_W-1:0] exp_mat;

    task automatic chk(input string name, input logic [MAT_W-1:0] act, input logic [MAT_W-1:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Snapshot monitor: compares the DUT against each queued expectation.
    always @(negedge clock) begin
        snap_t s;
        if (snap_q.size() != 0) begin
            s = snap_q.pop_front();
            chk("entry_value", MAT_W'(bus.entry_value), MAT_W'(s.entry));
            chk("row_idx", MAT_W'(bus.row_idx), MAT_W'(s.rowv));
            chk("col_idx", MAT_W'(bus.col_idx), MAT_W'(s.col));
            chk("ready", MAT_W'(bus.ready), MAT_W'(s.ready));
            chk("matrix_valid", MAT_W'(bus.matrix_valid), MAT_W'(s.mvalid));
            chk("error_overflow", MAT_W'(bus.error_overflow), MAT_W'(s.ovf));
            chk("error_incomplete", MAT_W'(bus.error_incomplete), MAT_W'(s.inc));
            chk("matrix_out", bus.matrix_out, s.mat);
        end
    end

    // Hand-off monitor: each rise of matrix_valid must match a queued matrix.
    always @(negedge clock) begin
        if (bus.matrix_valid && !mv_prev) begin
            if (hand_q.size() == 0) begin
                n_cmp++;
                n_bad++;
                $display("FAIL handoff: unexpected matrix_valid with %0h", bus.matrix_out);
            end else begin
                chk("handoff_matrix", bus.matrix_out, hand_q.pop_front());
            end
        end
        mv_prev = bus.matrix_valid;
    end

    task automatic expect_state(input logic [EW-1:0] entry, input logic [1:0] rowv, input logic col,
                                input logic rdy, input logic mv, input logic ovf, input logic inc);
        snap_t s;
        s.entry  = entry;
        s.row    = 1'b0;
        s.rowv   = rowv;
        s.col    = col;
        s.ready  = rdy;
        s.mvalid = mv;
        s.ovf    = ovf;
        s.inc    = inc;
        s.mat    = exp_mat;
        snap_q.push_back(s);
    endtask

    task automatic press(input logic [3:0] code, input int hold);
        @(posedge clock); #1;
        bus.key_code  = code;
        bus.key_valid = 1'b1;
        repeat (hold) @(posedge clock);
        #1 bus.key_valid = 1'b0;
        repeat (3) @(posedge clock);
        #1;
    endtask

    task automatic do_reset();
        @(posedge clock); #2;
        reset = 1'b0;
        repeat (2) @(posedge clock);
        #1 reset = 1'b1;
        exp_mat = '0;
    endtask

    task automatic commit(input logic [3:0] d);
        press(d, 5);
        press(4'hE, 5);
    endtask

    initial begin
        reset          = 1'b0;
        bus.key_code   = 4'h0;
        bus.key_valid  = 1'b0;
        bus.matrix_ack = 1'b0;
        exp_mat        = '0;
        repeat (2) @(posedge clock);
        #1 reset = 1'b1;
        expect_state(12'd0, 2'd0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);

        // Multi-digit entry and commit.
        press(4'h1, 5); press(4'h2, 5); press(4'h3, 5);
        expect_state(12'd123, 2'd0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        press(4'hE, 5);
        exp_mat = 72'h0000000000_0000_7B;
        expect_state(12'd0, 2'd0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);

        // Sign entry, negative commit, double toggle; ignored codes B/F.
        do_reset();
        press(4'hA, 5); press(4'h4, 5); press(4'hB, 5); press(4'h5, 5); press(4'hF, 5);
        expect_state(12'hFD3, 2'd0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        press(4'hE, 5);
        exp_mat = 72'h000000000000000FD3;
        expect_state(12'd0, 2'd0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        press(4'hA, 5); press(4'hA, 5); press(4'h7, 5);
        expect_state(12'd7, 2'd0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);

        // Saturation, negative saturation and clear keeping the sticky flag.
        do_reset();
        press(4'h9, 5); press(4'h9, 5); press(4'h9, 5); press(4'h9, 5);
        expect_state(12'd2047, 2'd0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
        press(4'hA, 5);
        expect_state(12'h801, 2'd0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
        press(4'hC, 5);
        expect_state(12'd0, 2'd0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0);

        // Early DONE flags incomplete and stays in LOAD.
        do_reset();
        commit(4'h1); commit(4'h2);
        press(4'hD, 5);
        exp_mat = 72'h000000000000002001;
        expect_state(12'd0, 2'd1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1);

        // Full matrix, hand-off, keys ignored in FULL and DONE, ack clears.
        do_reset();
        commit(4'h1); commit(4'h2); commit(4'h3); commit(4'h4); commit(4'h5); commit(4'h6);
        exp_mat = 72'h006005004003002001;
        expect_state(12'd0, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        press(4'h8, 5); press(4'hE, 5);
        expect_state(12'd0, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        hand_q.push_back(72'h006005004003002001);
        press(4'hD, 5);
        expect_state(12'd0, 2'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        press(4'h5, 5); press(4'hE, 5);
        expect_state(12'd0, 2'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        @(posedge clock); #1 bus.matrix_ack = 1'b1;
        @(posedge clock); #1 bus.matrix_ack = 1'b0;
        exp_mat = '0;
        expect_state(12'd0, 2'd0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);

        // Long hold yields a single digit event.
        press(4'h7, 40);
        expect_state(12'd7, 2'd0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);

        // Asynchronous reset mid-entry of the 4th element.
        do_reset();
        commit(4'h1); commit(4'h2); commit(4'h3);
        press(4'h4, 5);
        exp_mat = 72'h000000003002001;
        expect_state(12'd4, 2'd1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        @(posedge clock); @(posedge clock); #2;
        reset = 1'b0;
        exp_mat = '0;
        expect_state(12'd0, 2'd0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        @(posedge clock); #2 reset = 1'b1;

        // Key event coincident with ack in DONE: key dropped.
        commit(4'h1); commit(4'h2); commit(4'h3); commit(4'h4); commit(4'h5); commit(4'h6);
        hand_q.push_back(72'h006005004003002001);
        press(4'hD, 5);
        @(posedge clock); #1;
        bus.key_code   = 4'h8;
        bus.key_valid  = 1'b1;
        bus.matrix_ack = 1'b1;
        @(posedge clock); #1 bus.matrix_ack = 1'b0;
        repeat (4) @(posedge clock);
        #1 bus.key_valid = 1'b0;
        repeat (3) @(posedge clock);
        #1;
        exp_mat = '0;
        expect_state(12'd0, 2'd0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);

        // Drain with a bounded wait, then confirm every hand-off was seen.
        for (int i = 0; i < 20 && snap_q.size() != 0; i++) @(posedge clock);
        chk("snapshot_drain", MAT_W'(snap_q.size()), MAT_W'(0));
        chk("handoff_drain", MAT_W'(hand_q.size()), MAT_W'(0));
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
